// File: rtl/digota_pkg.sv
// rtl/digota_pkg.sv - shared state, mode code and drive encodings for the DIGOTA drive sequencer.
package digota_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_DEAD    = 3'd1,
      ST_DRV_P   = 3'd2,
      ST_DRV_N   = 3'd3,
      ST_DRV_CMP = 3'd4,
      ST_DRV_CMN = 3'd5
   } state_e;

   localparam logic [1:0] CODE_N   = 2'b10;
   localparam logic [1:0] CODE_P   = 2'b01;
   localparam logic [1:0] CODE_CMP = 2'b11;
   localparam logic [1:0] CODE_CMN = 2'b00;

   typedef struct packed {
      logic opmos;
      logic onmos;
      logic cmpmos;
      logic cmnmos;
   } drive_t;

   localparam drive_t DRV_OFF = 4'b1010;

   function automatic state_e code_to_state(input logic [1:0] code);
      case (code)
         CODE_N:   return ST_DRV_N;
         CODE_P:   return ST_DRV_P;
         CODE_CMP: return ST_DRV_CMP;
         default:  return ST_DRV_CMN;
      endcase
   endfunction

   // Only a DRV_* state turns on a device; every other state decodes to all-off.
   function automatic drive_t state_to_drive(input state_e st);
      drive_t d;
      d = DRV_OFF;
      case (st)
         ST_DRV_P:   d.opmos  = 1'b0;
         ST_DRV_N:   d.onmos  = 1'b1;
         ST_DRV_CMP: d.cmpmos = 1'b0;
         ST_DRV_CMN: d.cmnmos = 1'b1;
         default:    d = DRV_OFF;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/digota_in_filt.sv
// rtl/digota_in_filt.sv - comparator code synchroniser plus run-length glitch filter.
module digota_in_filt #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 2,
   parameter int W           = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [W-1:0] dout_nxt
);
   localparam int CW = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYC);

   logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
   logic [W-1:0]                  cand_q, cand_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [W-1:0]                  filt_q, filt_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      cand_d = sync_q[SYNC_STAGES-1];
      if (sync_q[SYNC_STAGES-1] == cand_q) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
         cnt_d = CW'(1);
      end
      // The filtered code moves on the edge that completes a FILT_CYC-long run.
      filt_d = filt_q;
      if (cnt_d == CNT_MAX) begin
         filt_d = cand_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         filt_q <= '0;
      end else begin
         sync_q <= sync_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign dout     = filt_q;
   assign dout_nxt = filt_d;

endmodule

// File: rtl/digota_drive_ctrl.sv
// rtl/digota_drive_ctrl.sv - DIGOTA drive sequencer with dead time; DIGOTA_DRIVE_CTRL_STAT_EN adds a DEAD-entry counter.
module digota_drive_ctrl
   import digota_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 2,
   parameter int DEAD_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              inpb,
   input  logic              inmb,
   input  logic [DEAD_W-1:0] dead_cyc,
`ifdef DIGOTA_DRIVE_CTRL_STAT_EN
   input  logic              stat_clr,
   output logic [15:0]       stat_cnt,
`endif
   output logic              opmos,
   output logic              onmos,
   output logic              cmpmos,
   output logic              cmnmos,
   output logic [2:0]        state_o
);
   state_e            state_q, state_d;
   logic [DEAD_W-1:0] dcnt_q, dcnt_d;
   drive_t            drive_q, drive_d;
   logic [1:0]        filt_code, filt_code_nxt;
   logic [DEAD_W-1:0] dead_len;

   digota_in_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYC   (FILT_CYC),
      .W          (2)
   ) u_in_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     ({inpb, inmb}),
      .dout    (filt_code),
      .dout_nxt(filt_code_nxt)
   );

   assign dead_len = (dead_cyc == '0) ? DEAD_W'(1) : dead_cyc;

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      if (!en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_DEAD;
               dcnt_d  = dead_len;
            end
            ST_DEAD: begin
               // Exit picks up the code the filter settles on at this same edge.
               if (dcnt_q <= DEAD_W'(1)) begin
                  state_d = code_to_state(filt_code_nxt);
               end else begin
                  dcnt_d = dcnt_q - 1'b1;
               end
            end
            default: begin
               if (code_to_state(filt_code) != state_q) begin
                  state_d = ST_DEAD;
                  dcnt_d  = dead_len;
               end
            end
         endcase
      end
      drive_d = state_to_drive(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         dcnt_q  <= '0;
         drive_q <= DRV_OFF;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         drive_q <= drive_d;
      end
   end

   assign opmos   = drive_q.opmos;
   assign onmos   = drive_q.onmos;
   assign cmpmos  = drive_q.cmpmos;
   assign cmnmos  = drive_q.cmnmos;
   assign state_o = state_q;

`ifdef DIGOTA_DRIVE_CTRL_STAT_EN
   logic [15:0] stat_q, stat_d;
   logic        code_chg;

   // Only a drive-to-DEAD transition counts; the OFF-to-DEAD enable path does not.
   assign code_chg = (state_q != ST_OFF) && (state_q != ST_DEAD) && (state_d == ST_DEAD);

   always_comb begin
      stat_d = stat_q;
      if (stat_clr) begin
         stat_d = '0;
      end else if (code_chg && (stat_q != 16'hFFFF)) begin
         stat_d = stat_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_cnt = stat_q;
`endif

endmodule
